wb_unit: RTL

Write-back unit driving the register file write port (Awr, Din, WrEn). Accepts results from the ALU and memory stages over valid/ready handshakes, buffers them in an in-order queue, and retires one write per cycle. Also reports pending writes per read address so decode can stall on hazards.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 75 +++++++
 rtl/wb_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back unit (wb_unit) and its queue
// (wb_fifo).
//   ADDR_W     : register file address width
//   DATA_W     : register file data width
//   wb_entry_t : one pending register write {adr, data}
//   is_r0()    : true for the hard-wired zero register, which is never written
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_r0(input logic [ADDR_W-1:0] adr);
    return (adr == '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry in-order circular buffer of pending register writes.
// Two ordered write ports (a is older than b) and one pop port. Pointers are
// PW bits wide, so they wrap modulo DEPTH for free (DEPTH is a power of two).
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   push_a, entry_a    : older push; written at the tail
//   push_b, entry_b    : younger push; written after entry_a when both fire
//   pop                : drop the head entry (caller guarantees count > 0)
//   head_entry         : entry at the head pointer
//   head               : head pointer, for age-ordered scans by the caller
//   count              : number of valid entries (0..DEPTH)
//   entries            : raw storage array, valid slots are head..head+count-1
//
// The caller's ready logic guarantees pushes never exceed free space, so no
// overflow guard is kept here.
// ---------------------------------------------------------------------------
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_a,
  input  wb_entry_t       entry_a,
  input  logic            push_b,
  input  wb_entry_t       entry_b,
  input  logic            pop,
  output wb_entry_t       head_entry,
  output logic [PW-1:0]   head,
  output logic [CW-1:0]   count,
  output wb_entry_t       entries [DEPTH]
);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      tail_q  <= tail_q + PW'(push_a) + PW'(push_b);
      count_q <= count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  // Storage is data only; slot validity is implied by head/count, so the
  // array needs no reset and stale contents are simply ignored.
  always_ff @(posedge clk) begin
    if (push_a) begin
      mem_q[tail_q] <= entry_a;
    end
    if (push_b) begin
      mem_q[push_a ? (tail_q + PW'(1)) : tail_q] <= entry_b;
    end
  end

  assign head_entry = mem_q[head_q];
  assign head       = head_q;
  assign count      = count_q;
  assign entries    = mem_q;

endmodule

// File: rtl/wb_unit.sv
// ---------------------------------------------------------------------------
// wb_unit
// Write-back unit driving the register file write port. Accepts ALU and load
// results over valid/ready handshakes, queues them in order (wb_fifo) and
// retires one write per cycle through a registered output stage. Reports
// pending writes against two decode read addresses for hazard stalls.
//
// Build option: define WB_FWD_EN to add the forwarding outputs
// FwdHit1/FwdHit2 and Fwd1/Fwd2 (data of the youngest pending write).
//
// Ports
//   Clk, Rst_n                   : clock, asynchronous active-low reset
//   AluValid/AluReady/AluAdr/AluData : ALU result handshake
//   MemValid/MemReady/MemAdr/MemData : load result handshake
//   Awr, Din, WrEn               : registered register file write port
//   Ard1, Ard2                   : decode read addresses
//   Busy1, Busy2                 : a write to Ard1/Ard2 is pending (comb.)
//   FwdHit1/2, Fwd1/2            : (WB_FWD_EN only) forwarding hit and data
// ---------------------------------------------------------------------------
module wb_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              AluValid,
  output logic              AluReady,
  input  logic [ADDR_W-1:0] AluAdr,
  input  logic [DATA_W-1:0] AluData,
  input  logic              MemValid,
  output logic              MemReady,
  input  logic [ADDR_W-1:0] MemAdr,
  input  logic [DATA_W-1:0] MemData,
  output logic [ADDR_W-1:0] Awr,
  output logic [DATA_W-1:0] Din,
  output logic              WrEn,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  output logic              Busy1,
  output logic              Busy2
`ifdef WB_FWD_EN
  ,
  output logic              FwdHit1,
  output logic              FwdHit2,
  output logic [DATA_W-1:0] Fwd1,
  output logic [DATA_W-1:0] Fwd2
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]  count;
  logic [PW-1:0]  head;
  logic [CW-1:0]  free;
  wb_entry_t      head_entry;
  wb_entry_t      entries [DEPTH];

  logic           mem_acc;
  logic           alu_acc;
  logic           push_mem;
  logic           push_alu;
  logic           push_a;
  logic           push_b;
  wb_entry_t      entry_a;
  wb_entry_t      entry_b;
  logic           pop;

  logic              vld_p1;
  logic [ADDR_W-1:0] adr_p1;
  logic [DATA_W-1:0] data_p1;

  // ---- p0: handshake and enqueue ----

  // A pop happens every cycle the queue is non-empty, so the slot being
  // vacated this cycle is already counted as free.
  always_comb begin
    free = CW'(DEPTH) - count + CW'(count != '0);
  end

  // MEM has priority for the last free slot; neither ready looks at its own
  // valid, only the ALU ready looks at MemValid.
  always_comb begin
    MemReady = Rst_n && (free != '0);
    AluReady = Rst_n && ((free >= CW'(2)) || ((free != '0) && !MemValid));
  end

  // Handshakes to r0 complete but leave nothing in the queue.
  always_comb begin
    mem_acc  = MemValid && MemReady;
    alu_acc  = AluValid && AluReady;
    push_mem = mem_acc && !is_r0(MemAdr);
    push_alu = alu_acc && !is_r0(AluAdr);
  end

  // Compact the two sources onto the ordered fifo ports: MEM is always the
  // older entry when both are written in the same cycle.
  always_comb begin
    push_a  = push_mem || push_alu;
    push_b  = push_mem && push_alu;
    entry_a = push_mem ? wb_entry_t'{adr: MemAdr, data: MemData}
                       : wb_entry_t'{adr: AluAdr, data: AluData};
    entry_b = wb_entry_t'{adr: AluAdr, data: AluData};
    pop     = (count != '0);
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .push_a     (push_a),
    .entry_a    (entry_a),
    .push_b     (push_b),
    .entry_b    (entry_b),
    .pop        (pop),
    .head_entry (head_entry),
    .head       (head),
    .count      (count),
    .entries    (entries)
  );

  // ---- p1: register file write stage ----

  // Address and data hold their last value when idle, hence no else-clear.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_p1  <= 1'b0;
      adr_p1  <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop) begin
        adr_p1  <= head_entry.adr;
        data_p1 <= head_entry.data;
      end
    end
  end

  assign WrEn = vld_p1;
  assign Awr  = adr_p1;
  assign Din  = data_p1;

  // ---- hazard probes ----

  // Pending if the output stage or any valid queue slot targets ard.
  function automatic logic probe_hit(input logic [ADDR_W-1:0] ard);
    logic hit;
    hit = vld_p1 && (adr_p1 == ard);
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (entries[head + PW'(k)].adr == ard)) begin
        hit = 1'b1;
      end
    end
    return hit && !is_r0(ard);
  endfunction

  always_comb begin
    Busy1 = probe_hit(Ard1);
    Busy2 = probe_hit(Ard2);
  end

`ifdef WB_FWD_EN
  // Scan oldest to youngest (output stage, then queue head to tail) so the
  // last match, i.e. the youngest write, is the one that sticks.
  function automatic logic [DATA_W-1:0] probe_data(input logic [ADDR_W-1:0] ard);
    logic [DATA_W-1:0] d;
    d = '0;
    if (vld_p1 && (adr_p1 == ard)) begin
      d = data_p1;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (entries[head + PW'(k)].adr == ard)) begin
        d = entries[head + PW'(k)].data;
      end
    end
    if (is_r0(ard)) begin
      d = '0;
    end
    return d;
  endfunction

  always_comb begin
    FwdHit1 = Busy1;
    FwdHit2 = Busy2;
    Fwd1    = probe_data(Ard1);
    Fwd2    = probe_data(Ard2);
  end
`else
  // Queue data is only read through the head port in this build; fold the
  // rest into a sink so the unused storage bits are accounted for.
  logic entries_data_unused;
  always_comb begin
    entries_data_unused = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      entries_data_unused = entries_data_unused ^ (^entries[k].data);
    end
  end
`endif

endmodule
